// File: rtl/brick_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brick_pkg
//  Description : Shared definitions for the brick-field collision engine:
//                scan FSM state encoding, default playfield geometry and the
//                brick-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package brick_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default playfield geometry, in pixels.
    localparam int DEF_X0       = 100;
    localparam int DEF_Y0       = 100;
    localparam int DEF_B_WIDTH  = 150;
    localparam int DEF_B_HEIGHT = 40;
    localparam int DEF_GAP      = 20;
    localparam int DEF_BALL_R   = 10;

    // Width of an index able to address n items; never narrower than 1 bit.
    function automatic int brick_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/brick_hit_test.sv
`default_nettype none
// ============================================================================
//  Module      : brick_hit_test
//  Description : Combinational ball-versus-brick overlap test. The ball is a
//                square of half-size BALL_R centred on (i_x, i_y); the brick
//                box is [i_l, i_l+B_WIDTH] x [i_t, i_t+B_HEIGHT].
//  Ports       : i_x, i_y      ball centre (12 bit)
//                i_l, i_t      brick left / top edge (13 bit)
//                o_overlap     ball square touches the brick box
//                o_in_x_span   ball centre x lies within the brick's columns
//                o_in_y_span   ball centre y lies within the brick's rows
//  Revision    : 1.0 - initial release
// ============================================================================
module brick_hit_test
    import brick_pkg::*;
#(
    parameter int B_WIDTH  = DEF_B_WIDTH,
    parameter int B_HEIGHT = DEF_B_HEIGHT,
    parameter int BALL_R   = DEF_BALL_R
) (
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic [12:0] i_l,
    input  logic [12:0] i_t,
    output logic        o_overlap,
    output logic        o_in_x_span,
    output logic        o_in_y_span
);

    localparam logic [12:0] c_W = 13'(B_WIDTH);
    localparam logic [12:0] c_H = 13'(B_HEIGHT);
    localparam logic [12:0] c_R = 13'(BALL_R);

    // One extra bit of headroom so centre+BALL_R never wraps at the 12-bit edge.
    logic [12:0] w_x;
    logic [12:0] w_y;
    logic        w_ovl_x;
    logic        w_ovl_y;

    assign w_x = {1'b0, i_x};
    assign w_y = {1'b0, i_y};

    // Moving the radius to the other side of each inequality keeps the test
    // free of subtraction, so nothing can go negative near the origin.
    assign w_ovl_x = (w_x + c_R >= i_l) && (w_x <= i_l + c_W + c_R);
    assign w_ovl_y = (w_y + c_R >= i_t) && (w_y <= i_t + c_H + c_R);

    assign o_overlap   = w_ovl_x && w_ovl_y;
    assign o_in_x_span = (w_x >= i_l) && (w_x <= i_l + c_W);
    assign o_in_y_span = (w_y >= i_t) && (w_y <= i_t + c_H);

endmodule
`default_nettype wire

// File: rtl/brick_field_collider.sv
`default_nettype none
// ============================================================================
//  Module      : brick_field_collider
//  Description : ROWS x COLS brick field with per-brick hit points. Each
//                accepted ball-position strobe triggers a scan of one brick
//                per pclk; the first live, overlapping brick (outside the
//                post-hit lockout) is struck and the scan ends early.
//  Ports       : pclk, rst_n          clock, asynchronous active-low reset
//                pos_valid, x_pos,    ball-centre strobe (dropped while busy)
//                y_pos
//                level_reset          synchronous restore of the whole field
//                busy, scan_done      scan in progress / end-of-scan pulse
//                hit, hit_idx,        strike pulse, struck brick index and
//                bounce_x, bounce_y   velocity-reversal flags
//                blocks_out,          destroyed-brick mask / all destroyed
//                all_cleared
//  Revision    : 1.0 - initial release
// ============================================================================
module brick_field_collider
    import brick_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int X0          = DEF_X0,
    parameter int Y0          = DEF_Y0,
    parameter int B_WIDTH     = DEF_B_WIDTH,
    parameter int B_HEIGHT    = DEF_B_HEIGHT,
    parameter int GAP         = DEF_GAP,
    parameter int BALL_R      = DEF_BALL_R,
    parameter int HP_W        = 2,
    parameter int HP_INIT     = 2,
    parameter int LOCK_FRAMES = 4
) (
    input  logic                                  pclk,
    input  logic                                  rst_n,
    input  logic                                  pos_valid,
    input  logic [11:0]                           x_pos,
    input  logic [11:0]                           y_pos,
    input  logic                                  level_reset,
    output logic                                  busy,
    output logic                                  scan_done,
    output logic                                  hit,
    output logic [brick_idx_width(ROWS*COLS)-1:0] hit_idx,
    output logic                                  bounce_x,
    output logic                                  bounce_y,
    output logic [ROWS*COLS-1:0]                  blocks_out,
    output logic                                  all_cleared
);

    localparam int c_N  = ROWS * COLS;
    localparam int c_IW = brick_idx_width(c_N);
    localparam int c_CW = brick_idx_width(COLS);
    localparam int c_LW = brick_idx_width(LOCK_FRAMES + 1);

    localparam logic [12:0]     c_X0     = 13'(X0);
    localparam logic [12:0]     c_Y0     = 13'(Y0);
    localparam logic [12:0]     c_X_STEP = 13'(B_WIDTH + GAP);
    localparam logic [12:0]     c_Y_STEP = 13'(B_HEIGHT + GAP);
    localparam logic [HP_W-1:0] c_HP0    = HP_W'(HP_INIT);
    localparam logic [c_LW-1:0] c_LOCK   = c_LW'(LOCK_FRAMES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,       state_d;
    logic [11:0]       x_q,           x_d;
    logic [11:0]       y_q,           y_d;
    logic [c_IW-1:0]   idx_q,         idx_d;
    logic [c_CW-1:0]   col_q,         col_d;
    logic [12:0]       l_q,           l_d;
    logic [12:0]       t_q,           t_d;
    logic [c_LW-1:0]   lock_q,        lock_d;
    logic              scan_hit_q,    scan_hit_d;
    logic [HP_W-1:0]   hp_q [c_N];
    logic [HP_W-1:0]   hp_d [c_N];

    logic              busy_q,        busy_d;
    logic              scan_done_q,   scan_done_d;
    logic              hit_q,         hit_d;
    logic [c_IW-1:0]   hit_idx_q,     hit_idx_d;
    logic              bounce_x_q,    bounce_x_d;
    logic              bounce_y_q,    bounce_y_d;
    logic [c_N-1:0]    blocks_q,      blocks_d;
    logic              all_cleared_q, all_cleared_d;

    logic              w_overlap;
    logic              w_in_x;
    logic              w_in_y;
    logic [HP_W-1:0]   w_hp_cur;
    logic              w_hit;

    // ------------------------------------------------------------------
    // Geometry test for the brick currently under the scan pointer
    // ------------------------------------------------------------------
    brick_hit_test #(
        .B_WIDTH  (B_WIDTH),
        .B_HEIGHT (B_HEIGHT),
        .BALL_R   (BALL_R)
    ) u_hit_test (
        .i_x         (x_q),
        .i_y         (y_q),
        .i_l         (l_q),
        .i_t         (t_q),
        .o_overlap   (w_overlap),
        .o_in_x_span (w_in_x),
        .o_in_y_span (w_in_y)
    );

    // Hit points of the brick being evaluated.
    always_comb begin
        w_hp_cur = '0;
        for (int i = 0; i < c_N; i++) begin
            if (idx_q == c_IW'(i)) begin
                w_hp_cur = hp_q[i];
            end
        end
    end

    assign w_hit = w_overlap && (w_hp_cur != '0) && (lock_q == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        idx_d         = idx_q;
        col_d         = col_q;
        l_d           = l_q;
        t_d           = t_q;
        lock_d        = lock_q;
        scan_hit_d    = scan_hit_q;
        busy_d        = busy_q;
        scan_done_d   = 1'b0;
        hit_d         = 1'b0;
        hit_idx_d     = hit_idx_q;
        bounce_x_d    = bounce_x_q;
        bounce_y_d    = bounce_y_q;
        for (int i = 0; i < c_N; i++) begin
            hp_d[i]     = hp_q[i];
            blocks_d[i] = (hp_q[i] == '0);
        end
        all_cleared_d = &blocks_d;

        if (level_reset) begin
            // Overrides any scan in flight; no hit or scan_done escapes.
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            lock_d     = '0;
            scan_hit_d = 1'b0;
            for (int i = 0; i < c_N; i++) begin
                hp_d[i] = c_HP0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pos_valid) begin
                        x_d        = x_pos;
                        y_d        = y_pos;
                        idx_d      = '0;
                        col_d      = '0;
                        l_d        = c_X0;
                        t_d        = c_Y0;
                        scan_hit_d = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (w_hit) begin
                        for (int i = 0; i < c_N; i++) begin
                            if (idx_q == c_IW'(i)) begin
                                hp_d[i] = hp_q[i] - 1'b1;
                            end
                        end
                        lock_d     = c_LOCK;
                        scan_hit_d = 1'b1;
                        hit_d      = 1'b1;
                        hit_idx_d  = idx_q;
                        // Centre inside the x span means a top/bottom face hit,
                        // inside the y span a side hit; outside both is a corner.
                        bounce_y_d = w_in_x || !(w_in_x || w_in_y);
                        bounce_x_d = w_in_y || !(w_in_x || w_in_y);
                        state_d    = ST_DONE;
                    end else if (idx_q == c_IW'(c_N - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        // Edges advance by addition only; column wrap moves
                        // back to the left edge and down one row.
                        if (col_q == c_CW'(COLS - 1)) begin
                            col_d = '0;
                            l_d   = c_X0;
                            t_d   = t_q + c_Y_STEP;
                        end else begin
                            col_d = col_q + 1'b1;
                            l_d   = l_q + c_X_STEP;
                        end
                    end
                end

                ST_DONE: begin
                    scan_done_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                    // A strobe that produced a hit does not count toward the
                    // lockout it just started.
                    if ((lock_q != '0) && !scan_hit_q) begin
                        lock_d = lock_q - 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            idx_q         <= '0;
            col_q         <= '0;
            l_q           <= '0;
            t_q           <= '0;
            lock_q        <= '0;
            scan_hit_q    <= 1'b0;
            for (int i = 0; i < c_N; i++) begin
                hp_q[i] <= c_HP0;
            end
            busy_q        <= 1'b0;
            scan_done_q   <= 1'b0;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
            bounce_x_q    <= 1'b0;
            bounce_y_q    <= 1'b0;
            blocks_q      <= '0;
            all_cleared_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            idx_q         <= idx_d;
            col_q         <= col_d;
            l_q           <= l_d;
            t_q           <= t_d;
            lock_q        <= lock_d;
            scan_hit_q    <= scan_hit_d;
            for (int i = 0; i < c_N; i++) begin
                hp_q[i] <= hp_d[i];
            end
            busy_q        <= busy_d;
            scan_done_q   <= scan_done_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
            bounce_x_q    <= bounce_x_d;
            bounce_y_q    <= bounce_y_d;
            blocks_q      <= blocks_d;
            all_cleared_q <= all_cleared_d;
        end
    end

    assign busy        = busy_q;
    assign scan_done   = scan_done_q;
    assign hit         = hit_q;
    assign hit_idx     = hit_idx_q;
    assign bounce_x    = bounce_x_q;
    assign bounce_y    = bounce_y_q;
    assign blocks_out  = blocks_q;
    assign all_cleared = all_cleared_q;

endmodule
`default_nettype wire

// File: tb/tb_brick_field_collider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brick_field_collider
//  Description : Self-checking bench for brick_field_collider with default
//                geometry. A small reference model tracks hit points and the
//                lockout counter and predicts each scan from plain geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_brick_field_collider;

    localparam int ROWS = 4, COLS = 4, N = 16;
    localparam int X0 = 100, Y0 = 100, BW = 150, BH = 40, GAP = 20, R = 10;
    localparam int HP_INIT = 2, LOCK = 4;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pos_valid = 1'b0;
    logic        level_reset = 1'b0;
    logic [11:0] x_pos = '0;
    logic [11:0] y_pos = '0;
    logic        busy, scan_done, hit, bounce_x, bounce_y, all_cleared;
    logic [3:0]  hit_idx;
    logic [15:0] blocks_out;

    int checks   = 0;
    int failures = 0;

    int hp_m [N];
    int lock_m;

    always #5 pclk = ~pclk;

    brick_field_collider dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .pos_valid   (pos_valid),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .level_reset (level_reset),
        .busy        (busy),
        .scan_done   (scan_done),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .bounce_x    (bounce_x),
        .bounce_y    (bounce_y),
        .blocks_out  (blocks_out),
        .all_cleared (all_cleared)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < N; i++) hp_m[i] = HP_INIT;
        lock_m = 0;
    endtask

    function automatic logic [15:0] model_blocks();
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < N; i++) b[i] = (hp_m[i] == 0);
        return b;
    endfunction

    // Predicts one scan and updates the model state accordingly.
    task automatic model_scan(input int x, input int y, output bit h, output int idx,
                              output bit bx, output bit by);
        int  l, t;
        bit  ox, oy, inx, iny;
        h = 0; idx = 0; bx = 0; by = 0;
        if (lock_m == 0) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    l  = X0 + c * (BW + GAP);
                    t  = Y0 + r * (BH + GAP);
                    ox = (x + R >= l) && (x <= l + BW + R);
                    oy = (y + R >= t) && (y <= t + BH + R);
                    if (!h && ox && oy && hp_m[r * COLS + c] > 0) begin
                        h   = 1;
                        idx = r * COLS + c;
                        inx = (x >= l) && (x <= l + BW);
                        iny = (y >= t) && (y <= t + BH);
                        by  = inx || !(inx || iny);
                        bx  = iny || !(inx || iny);
                    end
                end
            end
        end
        if (h) begin
            hp_m[idx] = hp_m[idx] - 1;
            lock_m    = LOCK;
        end else if (lock_m > 0) begin
            lock_m = lock_m - 1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Cycle 0 is the cycle pos_valid is driven; cycle k is sampled 1ns after
    // the k-th rising edge that follows it.
    task automatic do_strobe(input int x, input int y, input int extra_at, input int win);
        bit          eh, ebx, eby;
        int          eidx, hit_cnt, hit_cyc, done_cnt, done_cyc;
        logic [3:0]  oidx;
        logic        obx, oby, busy1, busy_done, clr_done;
        logic [15:0] blk_done;
        logic [15:0] eblk;
        model_scan(x, y, eh, eidx, ebx, eby);
        hit_cnt = 0; hit_cyc = 0; done_cnt = 0; done_cyc = 0;
        oidx = '0; obx = 0; oby = 0; busy1 = 0; busy_done = 1; clr_done = 0; blk_done = '0;
        @(negedge pclk);
        x_pos = 12'(x); y_pos = 12'(y); pos_valid = 1'b1;
        @(posedge pclk); #1;
        pos_valid = 1'b0;
        for (int cyc = 1; cyc <= win; cyc++) begin
            if (cyc > 1) begin @(posedge pclk); #1; end
            if (cyc == 1) busy1 = busy;
            if (hit) begin
                hit_cnt++; hit_cyc = cyc; oidx = hit_idx; obx = bounce_x; oby = bounce_y;
            end
            if (scan_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc; busy_done = busy; blk_done = blocks_out; clr_done = all_cleared;
                end
            end
            if (cyc == extra_at) begin
                x_pos = 12'($urandom_range(0, 900)); y_pos = 12'($urandom_range(0, 450));
                pos_valid = 1'b1;
            end else begin
                pos_valid = 1'b0;
            end
            if (extra_at == 0 && done_cnt > 0) break;
        end
        pos_valid = 1'b0;
        eblk = model_blocks();
        check("hit_count", hit_cnt, eh ? 1 : 0);
        if (eh) begin
            check("hit_latency", hit_cyc, eidx + 2);
            check("hit_idx", {28'd0, oidx}, eidx);
            check("bounce_x", {31'd0, obx}, {31'd0, ebx});
            check("bounce_y", {31'd0, oby}, {31'd0, eby});
        end
        check("scan_done_count", done_cnt, 1);
        check("scan_done_latency", done_cyc, eh ? eidx + 3 : N + 2);
        check("busy_during_scan", {31'd0, busy1}, 1);
        check("busy_at_done", {31'd0, busy_done}, 0);
        check("blocks_out", {16'd0, blk_done}, {16'd0, eblk});
        check("all_cleared", {31'd0, clr_done}, {31'd0, &eblk});
    endtask

    task automatic do_level_reset();
        @(negedge pclk); level_reset = 1'b1;
        @(negedge pclk); level_reset = 1'b0;
        model_reset();
        @(posedge pclk); #1;
    endtask

    task automatic drain_lock();
        while (lock_m > 0) do_strobe(600, 700, 0, N + 6);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int hcnt, dcnt;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_hit", {31'd0, hit}, 0);
        @(negedge pclk); rst_n = 1'b1;
        @(posedge pclk); #1;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_scan_done", {31'd0, scan_done}, 0);
        check("reset_hit", {31'd0, hit}, 0);
        check("reset_hit_idx", {28'd0, hit_idx}, 0);
        check("reset_bounce", {30'd0, bounce_x, bounce_y}, 0);
        check("reset_blocks", {16'd0, blocks_out}, 0);
        check("reset_all_cleared", {31'd0, all_cleared}, 0);

        // Miss below the field, then bottom-face hit on brick 0.
        do_strobe(600, 700, 0, N + 6);
        do_strobe(175, 145, 0, N + 6);
        // Lockout: four suppressed strobes, fifth destroys brick 0, sixth misses.
        for (int k = 0; k < 6; k++) do_strobe(175, 145, 0, N + 6);
        check("brick0_destroyed", {31'd0, blocks_out[0]}, 1);

        // Corner hit, then side hit on brick 5.
        do_level_reset();
        do_strobe(95, 95, 0, N + 6);
        drain_lock();
        do_strobe(265, 180, 0, N + 6);
        drain_lock();

        // pos_valid while busy is dropped: exactly one scan_done.
        do_strobe(685, 300, 3, 50);
        drain_lock();

        // level_reset mid-scan toward brick 15 aborts the scan.
        do_level_reset();
        hcnt = 0; dcnt = 0;
        @(negedge pclk); x_pos = 12'd685; y_pos = 12'd300; pos_valid = 1'b1;
        @(posedge pclk); #1; pos_valid = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc > 1) begin @(posedge pclk); #1; end
            if (hit) hcnt++;
            if (scan_done) dcnt++;
            if (cyc == 4) check("abort_busy", {31'd0, busy}, 0);
            level_reset = (cyc == 3);
        end
        level_reset = 1'b0;
        model_reset();
        check("abort_hits", hcnt, 0);
        check("abort_scan_done", dcnt, 0);
        check("abort_blocks", {16'd0, blocks_out}, 0);

        // level_reset together with pos_valid: strobe is dropped.
        dcnt = 0;
        @(negedge pclk); x_pos = 12'd175; y_pos = 12'd145; pos_valid = 1'b1; level_reset = 1'b1;
        @(posedge pclk); #1; pos_valid = 1'b0; level_reset = 1'b0;
        check("collide_busy", {31'd0, busy}, 0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge pclk); #1;
            if (scan_done || hit) dcnt++;
        end
        check("collide_no_scan", dcnt, 0);

        // Clear the whole field, respecting lockouts.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < HP_INIT; k++) begin
                do_strobe(X0 + (i % COLS) * (BW + GAP) + BW / 2,
                          Y0 + (i / COLS) * (BH + GAP) + BH / 2, 0, N + 6);
                drain_lock();
            end
        end
        check("field_cleared", {31'd0, all_cleared}, 1);
        check("field_blocks", {16'd0, blocks_out}, 32'h0000ffff);
        do_level_reset();
        @(posedge pclk); #1;
        check("level_reset_all_cleared", {31'd0, all_cleared}, 0);
        check("level_reset_blocks", {16'd0, blocks_out}, 0);

        // Randomized strobes, including far-out positions near the 12-bit limit.
        for (int k = 0; k < 40; k++) begin
            if (k % 10 == 9)
                do_strobe($urandom_range(3900, 4095), $urandom_range(3900, 4095), 0, N + 6);
            else
                do_strobe($urandom_range(0, 900), $urandom_range(0, 450), 0, N + 6);
        end

        // Make sure brick 0 is destroyed, then assert async reset mid-scan.
        drain_lock();
        while (hp_m[0] > 0) begin
            do_strobe(175, 120, 0, N + 6);
            drain_lock();
        end
        check("pre_async_blocks0", {31'd0, blocks_out[0]}, 1);
        @(negedge pclk); x_pos = 12'd685; y_pos = 12'd300; pos_valid = 1'b1;
        @(posedge pclk); #1; pos_valid = 1'b0;
        @(posedge pclk); #1;
        #1 rst_n = 1'b0;
        #1;
        check("async_busy", {31'd0, busy}, 0);
        check("async_blocks", {16'd0, blocks_out}, 0);
        check("async_hit", {31'd0, hit}, 0);
        @(negedge pclk); rst_n = 1'b1;
        model_reset();
        do_strobe(175, 145, 0, N + 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/brick_field_collider.md
Name: brick_field_collider

Overview:
- Parametrised brick-field collision engine for the breakout datapath, successor to the fixed 4x4 collision detector.
- Holds a ROWS x COLS grid of bricks, each with a hit-point counter.
- On each ball-position strobe it scans the field one brick per pclk and reports at most one hit per strobe, with bounce direction.
- Sits between the ball-motion block (position source) and the brick renderer/score logic (consumers of the destroyed-brick mask and hit pulses).

Parameters:
- ROWS, 4, brick rows
- COLS, 4, brick columns (N = ROWS*COLS; IW = max(1,$clog2(N)))
- X0, 100, left edge of column 0 (px)
- Y0, 100, top edge of row 0 (px)
- B_WIDTH, 150, brick width (px)
- B_HEIGHT, 40, brick height (px)
- GAP, 20, spacing between bricks, both axes (px)
- BALL_R, 10, ball half-size (px)
- HP_W, 2, hit-point counter width
- HP_INIT, 2, hit points per brick after reset/level_reset; must satisfy 1..2^HP_W-1
- LOCK_FRAMES, 4, strobes during which hits are suppressed after a hit

Ports:
- pclk  in  1  pixel clock, sole clock
- rst_n  in  1  asynchronous active-low reset
- pos_valid  in  1  one-cycle strobe: x_pos/y_pos valid (once per frame)
- x_pos  in  12  ball centre x
- y_pos  in  12  ball centre y
- level_reset  in  1  synchronous restore of the whole field
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse at end of each accepted scan
- hit  out  1  one-cycle pulse: a brick was struck
- hit_idx  out  IW  index of the struck brick (row*COLS+col)
- bounce_x  out  1  valid with hit: reverse x velocity
- bounce_y  out  1  valid with hit: reverse y velocity
- blocks_out  out  N  bit i = 1 when brick i is destroyed (HP = 0)
- all_cleared  out  1  all bricks destroyed

Behaviour:
- Reset (rst_n low, asynchronous):
  - all HP = HP_INIT, lock = 0, state IDLE.
  - busy, scan_done, hit, hit_idx, bounce_x, bounce_y, blocks_out and all_cleared all 0.
- All outputs are registered.
- FSM states are IDLE, SCAN, DONE.
- IDLE:
  - pos_valid samples x_pos/y_pos into registers.
  - idx = 0; row/col counters and running edges L = X0, T = Y0 are reset.
  - Next state SCAN; busy = 1 from the next cycle.
- SCAN, evaluating brick idx each cycle:
  - Brick box is [L, L+B_WIDTH] x [T, T+B_HEIGHT].
  - Overlap test, in 13-bit unsigned arithmetic with no subtraction: x+BALL_R >= L and x <= L+B_WIDTH+BALL_R, and the same for y with T/B_HEIGHT.
  - Brick edges are advanced by adders only (L += B_WIDTH+GAP; on column wrap L = X0, T += B_HEIGHT+GAP). No multipliers.
- Hit condition is overlap, HP[idx] != 0 and lock == 0. On a hit:
  - HP[idx] decrements; lock = LOCK_FRAMES.
  - hit = 1 for the next cycle, with hit_idx = idx.
  - Face classification: bounce_y = 1 if centre x lies within [L, L+B_WIDTH]; bounce_x = 1 if centre y lies within [T, T+B_HEIGHT]; if neither (corner), both = 1.
  - The scan terminates early to DONE.
- Without a hit at idx = N-1, SCAN goes to DONE.
- Latency: hit for brick i is visible i+2 cycles after the pos_valid sampling edge. The worst-case scan is N+2 cycles.
- DONE:
  - scan_done = 1 for one cycle, busy = 0, return to IDLE.
  - If lock != 0 and this scan produced no hit, lock decrements.
- blocks_out[i] = (HP[i] == 0) and all_cleared = &blocks_out, both registered. They update the cycle after an HP change.
- Boundary and priority rules:
  - pos_valid while busy is dropped; there is no queueing.
  - Destroyed bricks never hit and never underflow.
  - Positions beyond the field produce no hit; the 13-bit widening prevents wrap.
  - level_reset has priority over everything, including mid-scan. It aborts the scan with no hit or scan_done. All HP = HP_INIT, lock = 0, state IDLE, busy = 0 next cycle.
  - level_reset and pos_valid in the same cycle: the level_reset applies and pos_valid is dropped.
  - Asynchronous reset mid-scan behaves identically to power-up reset.

Decomposition:
- Shared package brick_pkg:
  - FSM state enum.
  - Default geometry constants (X0, Y0, B_WIDTH, B_HEIGHT, GAP, BALL_R).
  - Brick-index width function.
- One combinational sub-module, brick_hit_test:
  - Inputs: ball x/y, L, T.
  - Outputs: overlap, in_x_span, in_y_span.
  - Parametrised by B_WIDTH/B_HEIGHT/BALL_R.
- HP storage stays in the top as an N x HP_W register array.

Test Plan:
- Reset: after rst_n release, all outputs 0, busy 0, blocks_out = 16'h0000; pos_valid at (600,700) -> no hit, scan_done 18 cycles later.
- Bottom-face hit: pos_valid (175,145) -> hit 2 cycles later, hit_idx 0, bounce_y 1, bounce_x 0; HP0 = 1, blocks_out[0] still 0.
- Lockout and destruction: repeat (175,145) -> no hit for 4 strobes; 5th strobe -> hit idx 0, then blocks_out[0] = 1; 6th strobe -> no hit.
- Corner and side hits:
  - pos (95,95) -> hit idx 0, bounce_x = bounce_y = 1.
  - pos (265,180) -> hit idx 5, bounce_x 1 only.
- Contention: pos_valid during busy -> ignored, exactly one scan_done. level_reset asserted 3 cycles into a scan toward idx 15 -> no hit, busy 0 next cycle, blocks_out 0.
- Clear the field: strike all 16 bricks twice, with lockouts respected -> all_cleared 1 one cycle after the final decrement; level_reset -> all_cleared 0.
